// File: rtl/block_ctl.sv
// Falling-block controller: spawn, left/right moves and frame-paced gravity on a COLS x ROWS grid.
// Latency: outputs registered, updated one pclk after the input pulse or frame tick; no backpressure.
// Optional BLOCK_CTL_FAST_DROP_EN: drop held in FALL makes gravity fire on every frame tick.
module block_ctl #(
    parameter int FALL_FRAMES = 30,
    parameter int X_ORIGIN    = 201,
    parameter int Y_ORIGIN    = 10,
    parameter int CELL        = 35,
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int SPAWN_COL   = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        left,
    input  logic        right,
    input  logic        drop,
    output logic [3:0]  col,
    output logic [4:0]  row,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy,
    output logic        landed
);

    localparam logic [3:0]  COL_MAX  = 4'(COLS - 1);
    localparam logic [4:0]  ROW_MAX  = 5'(ROWS - 1);
    localparam logic [5:0]  CNT_TOP  = 6'(FALL_FRAMES - 1);
    localparam logic [3:0]  COL_INIT = 4'(SPAWN_COL);
    localparam logic [11:0] X_ORG    = 12'(X_ORIGIN);
    localparam logic [11:0] Y_ORG    = 12'(Y_ORIGIN);
    localparam logic [11:0] CELL_W   = 12'(CELL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FALL = 2'd1,
        S_LAND = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        vsync_q;
    logic        vsync_vld;
    logic        tick;
    logic [5:0]  cnt, cnt_n;
    logic [3:0]  col_n;
    logic [4:0]  row_n;
    logic        grav;
    logic        fast;

`ifdef BLOCK_CTL_FAST_DROP_EN
    assign fast = drop;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign fast        = 1'b0;
`endif

    // vsync_vld keeps a vsync already high at reset release from counting as an edge
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            vsync_vld <= 1'b0;
            tick      <= 1'b0;
        end else begin
            vsync_q   <= vsync_in;
            vsync_vld <= 1'b1;
            tick      <= vsync_in & ~vsync_q & vsync_vld;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        cnt_n   = cnt;
        grav    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    col_n   = COL_INIT;
                    row_n   = 5'd0;
                    cnt_n   = 6'd0;
                    state_n = S_FALL;
                end
            end
            S_FALL: begin
                if (left && !right && col != 4'd0)
                    col_n = col - 4'd1;
                else if (right && !left && col != COL_MAX)
                    col_n = col + 4'd1;
                if (tick) begin
                    if (fast || cnt == CNT_TOP) begin
                        cnt_n = 6'd0;
                        grav  = 1'b1;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
                if (grav) begin
                    if (row != ROW_MAX)
                        row_n = row + 5'd1;
                    else
                        state_n = S_LAND;
                end
            end
            S_LAND: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            col    <= COL_INIT;
            row    <= 5'd0;
            cnt    <= 6'd0;
            xpos   <= X_ORG + CELL_W * {8'd0, COL_INIT};
            ypos   <= Y_ORG;
            busy   <= 1'b0;
            landed <= 1'b0;
        end else begin
            state  <= state_n;
            col    <= col_n;
            row    <= row_n;
            cnt    <= cnt_n;
            xpos   <= X_ORG + CELL_W * {8'd0, col_n};
            ypos   <= Y_ORG + CELL_W * {7'd0, row_n};
            busy   <= (state_n != S_IDLE);
            landed <= (state_n == S_LAND);
        end
    end

endmodule

// File: tb/tb_block_ctl.sv
// Bench for block_ctl with FALL_FRAMES=2: directed vector table, landing/reset/drop sequences,
// then random moves and ticks compared against a grid-level reference model.
module tb_block_ctl;

    localparam int FF = 2;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        start = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        drop = 1'b0;
    logic [3:0]  col;
    logic [4:0]  row;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;
    logic        landed;

    int n_chk = 0;
    int n_pass = 0;
    int land_cnt = 0;

    // reference model: block position, ticks since last gravity step, active flag
    int m_col, m_row, m_ticks, m_lands;
    bit m_act;

    block_ctl #(.FALL_FRAMES(FF)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .left(left), .right(right), .drop(drop),
        .col(col), .row(row), .xpos(xpos), .ypos(ypos),
        .busy(busy), .landed(landed)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (landed) land_cnt++;

    typedef struct {
        logic l, r, s, t;
        int   ec, er, eb;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_pos(input string nm, input int ec, input int er, input int eb);
        chk({nm, ".col"}, int'(col), ec);
        chk({nm, ".row"}, int'(row), er);
        chk({nm, ".xpos"}, int'(xpos), 201 + 35 * ec);
        chk({nm, ".ypos"}, int'(ypos), 10 + 35 * er);
        chk({nm, ".busy"}, int'(busy), eb);
    endtask

    // one operation: optional frame tick, with left/right/start pulses landing on the tick cycle
    task automatic step_op(input logic l, input logic r, input logic s, input logic t);
        if (t) begin
            @(negedge pclk) vsync_in = 1'b1;
            @(negedge pclk) begin left = l; right = r; start = s; end
            @(negedge pclk) begin left = 1'b0; right = 1'b0; start = 1'b0; end
            @(negedge pclk) vsync_in = 1'b0;
            @(negedge pclk);
            @(negedge pclk);
        end else begin
            @(negedge pclk) begin left = l; right = r; start = s; end
            @(negedge pclk) begin left = 1'b0; right = 1'b0; start = 1'b0; end
        end
    endtask

    task automatic model_op(input logic l, input logic r, input logic s, input logic t);
        if (!m_act) begin
            if (s) begin
                m_act = 1'b1; m_col = 4; m_row = 0; m_ticks = 0;
            end
        end else begin
            if (l && !r) m_col = (m_col > 0) ? m_col - 1 : 0;
            if (r && !l) m_col = (m_col < 9) ? m_col + 1 : 9;
            if (t) begin
                m_ticks++;
                if (m_ticks % FF == 0) begin
                    if (m_row < 19) m_row++;
                    else begin m_act = 1'b0; m_lands++; end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        land_cnt = 0;
        m_act = 1'b0; m_col = 4; m_row = 0; m_ticks = 0; m_lands = 0;
    endtask

    task automatic add(input logic l, r, s, t, input int ec, er, eb);
        vec_t v;
        v.l = l; v.r = r; v.s = s; v.t = t; v.ec = ec; v.er = er; v.eb = eb;
        tbl.push_back(v);
    endtask

    initial begin
        add(0, 0, 1, 0, 4, 0, 1);
        for (int i = 0; i < 5; i++)  add(1, 0, 0, 0, (3 - i > 0) ? 3 - i : 0, 0, 1);
        for (int i = 0; i < 12; i++) add(0, 1, 0, 0, (1 + i < 9) ? 1 + i : 9, 0, 1);
        add(1, 1, 0, 0, 9, 0, 1);
        add(0, 0, 0, 1, 9, 0, 1);
        add(1, 0, 0, 1, 8, 1, 1);

        do_reset();
        chk_pos("reset", 4, 0, 0);
        chk("reset.landed", int'(landed), 0);

        foreach (tbl[i]) begin
            step_op(tbl[i].l, tbl[i].r, tbl[i].s, tbl[i].t);
            chk_pos($sformatf("vec%0d", i), tbl[i].ec, tbl[i].er, tbl[i].eb);
        end

        // 38 more ticks make 40 since start: row 19 reached at tick 38, landing at tick 40
        repeat (36) step_op(0, 0, 0, 1);
        chk_pos("pre_land", 8, 19, 1);
        chk("pre_land.landed_cnt", land_cnt, 0);
        repeat (2) step_op(0, 0, 0, 1);
        chk_pos("land", 8, 19, 0);
        chk("land.landed_cnt", land_cnt, 1);
        repeat (4) step_op(0, 0, 0, 1);
        chk_pos("post_land", 8, 19, 0);
        chk("post_land.landed_cnt", land_cnt, 1);

        // asynchronous reset in the middle of a fall
        step_op(0, 0, 1, 0);
        step_op(0, 1, 0, 0);
        repeat (14) step_op(0, 0, 0, 1);
        chk_pos("mid_fall", 5, 7, 1);
        @(negedge pclk);
        #2 rst = 1'b1;
        vsync_in = 1'b1;
        #1;
        chk_pos("async_rst", 4, 0, 0);
        chk("async_rst.landed", int'(landed), 0);
        @(negedge pclk) begin rst = 1'b0; start = 1'b1; end
        @(negedge pclk) start = 1'b0;
        chk_pos("respawn", 4, 0, 1);
        // vsync was already high at release, so that level must not count as a tick
        @(negedge pclk) vsync_in = 1'b0;
        @(negedge pclk);
        step_op(0, 0, 0, 1);
        chk_pos("fresh_edge1", 4, 0, 1);
        step_op(0, 0, 0, 1);
        chk_pos("fresh_edge2", 4, 1, 1);

        drop = 1'b1;
        step_op(0, 0, 0, 1);
        step_op(0, 0, 0, 1);
        drop = 1'b0;
`ifdef BLOCK_CTL_FAST_DROP_EN
        chk_pos("drop", 4, 3, 1);
`else
        chk_pos("drop", 4, 2, 1);
`endif

        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic l, r, s, t;
            int   k;
            k = $urandom_range(0, 9);
            s = (!m_act && k < 5);
            t = (k < 4);
            l = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            if (s) t = 1'b0;
            step_op(l, r, s, t);
            model_op(l, r, s, t);
            chk_pos($sformatf("rnd%0d", i), m_col, m_row, int'(m_act));
            chk($sformatf("rnd%0d.lands", i), land_cnt, m_lands);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
